// File: rtl/cajero_multicuenta.sv
// Multi-account ATM controller: per-account balances, PIN attempt counters and locks.
// Optional per-session withdrawal cap enabled by defining CAJERO_LIMITE_RETIRO_EN.
module cajero_multicuenta #(
  parameter int N_CUENTAS     = 4,
  parameter int PIN_DIGITOS   = 4,
  parameter int MONTO_W       = 32,
  parameter int MAX_INTENTOS  = 3,
  parameter int LIMITE_RETIRO = 1000,
  localparam int CW = (N_CUENTAS > 1) ? $clog2(N_CUENTAS) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_tarjeta_recibida,
  input  logic [CW-1:0]          i_cuenta_id,
  input  logic [4*PIN_DIGITOS-1:0] i_pin,
  input  logic [3:0]             i_digito,
  input  logic                   i_digito_stb,
  input  logic [1:0]             i_tipo_trans,
  input  logic                   i_tipo_stb,
  input  logic [MONTO_W-1:0]     i_monto,
  input  logic                   i_monto_stb,
  output logic                   o_balance_actualizado,
  output logic                   o_entregar_dinero,
  output logic                   o_fondos_insuficientes,
  output logic                   o_pin_incorrecto,
  output logic                   o_advertencia,
  output logic                   o_desborde,
  output logic                   o_limite_excedido,
  output logic                   o_balance_valid,
  output logic                   o_bloqueo,
  output logic [MONTO_W-1:0]     o_balance_out
);

  localparam int PW = 4 * PIN_DIGITOS;
  localparam int DW = $clog2(PIN_DIGITOS + 1);
  localparam int IW = $clog2(MAX_INTENTOS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PIN, S_SELECCION, S_DEPOSITO, S_RETIRO, S_BLOQUEADO, S_FIN
  } estado_t;

  estado_t              r_estado;
  logic [CW-1:0]        r_cuenta;
  logic [DW-1:0]        r_cont;
  logic [PW-1:0]        r_shift;
  logic [MONTO_W-1:0]   r_saldo    [N_CUENTAS];
  logic [IW-1:0]        r_intentos [N_CUENTAS];
  logic [N_CUENTAS-1:0] r_bloq;

  logic [MONTO_W:0]     w_suma;
  logic [IW-1:0]        w_intentos_sig;
  logic                 w_fondos_ok;
  logic                 w_pin_ok;
  logic                 w_pin_completo;

  assign w_suma         = {1'b0, r_saldo[r_cuenta]} + {1'b0, i_monto};
  assign w_intentos_sig = r_intentos[r_cuenta] + IW'(1);
  assign w_fondos_ok    = (i_monto <= r_saldo[r_cuenta]);
  assign w_pin_ok       = (r_shift == i_pin);
  assign w_pin_completo = (r_cont == DW'(PIN_DIGITOS));

`ifdef CAJERO_LIMITE_RETIRO_EN
  logic [MONTO_W:0]   r_acum;
  logic [MONTO_W+1:0] w_acum_sig;
  logic               w_limite_ok;

  assign w_acum_sig  = {1'b0, r_acum} + {2'b00, i_monto};
  assign w_limite_ok = (w_acum_sig <= (MONTO_W+2)'(LIMITE_RETIRO));
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_estado <= S_IDLE;
      r_cuenta <= '0;
      r_cont   <= '0;
      r_shift  <= '0;
      r_bloq   <= '0;
      for (int k = 0; k < N_CUENTAS; k++) begin
        r_saldo[k]    <= '0;
        r_intentos[k] <= '0;
      end
`ifdef CAJERO_LIMITE_RETIRO_EN
      r_acum <= '0;
`endif
      o_balance_actualizado  <= 1'b0;
      o_entregar_dinero      <= 1'b0;
      o_fondos_insuficientes <= 1'b0;
      o_pin_incorrecto       <= 1'b0;
      o_advertencia          <= 1'b0;
      o_desborde             <= 1'b0;
      o_limite_excedido      <= 1'b0;
      o_balance_valid        <= 1'b0;
      o_bloqueo              <= 1'b0;
      o_balance_out          <= '0;
    end else begin
      o_balance_actualizado  <= 1'b0;
      o_entregar_dinero      <= 1'b0;
      o_fondos_insuficientes <= 1'b0;
      o_pin_incorrecto       <= 1'b0;
      o_advertencia          <= 1'b0;
      o_desborde             <= 1'b0;
      o_limite_excedido      <= 1'b0;
      o_balance_valid        <= 1'b0;

      // Card removal outranks any strobe arriving in the same cycle.
      if (r_estado != S_IDLE && !i_tarjeta_recibida) begin
        r_estado  <= S_IDLE;
        r_cont    <= '0;
        r_shift   <= '0;
        o_bloqueo <= 1'b0;
`ifdef CAJERO_LIMITE_RETIRO_EN
        r_acum    <= '0;
`endif
      end else begin
        case (r_estado)
          S_IDLE: begin
            if (i_tarjeta_recibida) begin
              r_cuenta <= i_cuenta_id;
              r_cont   <= '0;
              r_shift  <= '0;
              if (r_bloq[i_cuenta_id]) begin
                r_estado  <= S_BLOQUEADO;
                o_bloqueo <= 1'b1;
              end else begin
                r_estado <= S_PIN;
`ifdef CAJERO_LIMITE_RETIRO_EN
                r_acum   <= '0;
`endif
              end
            end
          end

          S_PIN: begin
            if (w_pin_completo) begin
              r_cont  <= '0;
              r_shift <= '0;
              if (w_pin_ok) begin
                r_intentos[r_cuenta] <= '0;
                r_estado             <= S_SELECCION;
              end else begin
                o_pin_incorrecto <= 1'b1;
                if (w_intentos_sig == IW'(MAX_INTENTOS - 1))
                  o_advertencia <= 1'b1;
                if (w_intentos_sig == IW'(MAX_INTENTOS)) begin
                  r_bloq[r_cuenta]     <= 1'b1;
                  r_intentos[r_cuenta] <= '0;
                  r_estado             <= S_BLOQUEADO;
                  o_bloqueo            <= 1'b1;
                end else begin
                  r_intentos[r_cuenta] <= w_intentos_sig;
                end
              end
            end else if (i_digito_stb) begin
              r_shift <= PW'({r_shift, i_digito});
              r_cont  <= r_cont + DW'(1);
            end
          end

          S_SELECCION: begin
            if (i_tipo_stb) begin
              case (i_tipo_trans)
                2'b00: r_estado <= S_DEPOSITO;
                2'b01: r_estado <= S_RETIRO;
                2'b10: begin
                  o_balance_out   <= r_saldo[r_cuenta];
                  o_balance_valid <= 1'b1;
                end
                default: r_estado <= S_FIN;
              endcase
            end
          end

          S_DEPOSITO: begin
            if (i_monto_stb) begin
              r_estado <= S_SELECCION;
              if (w_suma[MONTO_W]) begin
                o_desborde <= 1'b1;
              end else begin
                r_saldo[r_cuenta]     <= w_suma[MONTO_W-1:0];
                o_balance_actualizado <= 1'b1;
              end
            end
          end

          S_RETIRO: begin
            if (i_monto_stb) begin
              r_estado <= S_SELECCION;
              if (!w_fondos_ok) begin
                o_fondos_insuficientes <= 1'b1;
`ifdef CAJERO_LIMITE_RETIRO_EN
              end else if (!w_limite_ok) begin
                o_limite_excedido <= 1'b1;
`endif
              end else begin
                r_saldo[r_cuenta]     <= r_saldo[r_cuenta] - i_monto;
                o_balance_actualizado <= 1'b1;
                o_entregar_dinero     <= 1'b1;
`ifdef CAJERO_LIMITE_RETIRO_EN
                r_acum <= w_acum_sig[MONTO_W:0];
`endif
              end
            end
          end

          S_BLOQUEADO, S_FIN: begin
          end

          default: r_estado <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cajero_multicuenta.sv
// Randomized scoreboard bench for cajero_multicuenta against a transaction-level account model.
module tb_cajero_multicuenta;

  localparam int N   = 4;
  localparam int PD  = 4;
  localparam int MW  = 32;
  localparam int MI  = 3;
  localparam int LIM = 1000;

  localparam int P_ACT = 7, P_ENT = 6, P_FON = 5, P_PIN = 4;
  localparam int P_ADV = 3, P_DES = 2, P_LIM = 1, P_VAL = 0;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          tarjeta = 1'b0;
  logic [1:0]    cuentaId = '0;
  logic [15:0]   pinBus;
  logic [3:0]    digito = '0;
  logic          digitoStb = 1'b0;
  logic [1:0]    tipo = '0;
  logic          tipoStb = 1'b0;
  logic [MW-1:0] monto = '0;
  logic          montoStb = 1'b0;

  logic          balAct, entregar, fondos, pinInc, adv, desborde, limite, balValid, bloqueo;
  logic [MW-1:0] balOut;

  cajero_multicuenta #(
    .N_CUENTAS(N), .PIN_DIGITOS(PD), .MONTO_W(MW),
    .MAX_INTENTOS(MI), .LIMITE_RETIRO(LIM)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_tarjeta_recibida(tarjeta),
    .i_cuenta_id(cuentaId), .i_pin(pinBus), .i_digito(digito),
    .i_digito_stb(digitoStb), .i_tipo_trans(tipo), .i_tipo_stb(tipoStb),
    .i_monto(monto), .i_monto_stb(montoStb),
    .o_balance_actualizado(balAct), .o_entregar_dinero(entregar),
    .o_fondos_insuficientes(fondos), .o_pin_incorrecto(pinInc),
    .o_advertencia(adv), .o_desborde(desborde), .o_limite_excedido(limite),
    .o_balance_valid(balValid), .o_bloqueo(bloqueo), .o_balance_out(balOut)
  );

  always #5 clk = ~clk;

  // Account model: balances, attempts, locks, session withdrawal total.
  logic [15:0]     pinDe [N];
  longint unsigned saldoM [N];
  int              intentosM [N];
  bit              lockM [N];
  longint unsigned acumM = 0;
  bit              expBloqueo = 1'b0;

  always_comb pinBus = pinDe[cuentaId];

  typedef struct {
    logic [7:0]    pulsos;
    logic [MW-1:0] balance;
    int            ciclo;
  } esperado_t;

  esperado_t colaEsperada[$];
  int compared = 0;
  int mismatched = 0;
  int cycleCount = 0;

  always @(posedge clk) cycleCount++;

  function automatic void checkOutput(string nombre, logic [63:0] actual, logic [63:0] esperado);
    compared++;
    if (actual !== esperado) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", nombre, actual, esperado, cycleCount);
    end
  endfunction

  // Expected pulse becomes visible in the cycle after the next sampling edge.
  function automatic void pushEsperado(logic [7:0] p, logic [MW-1:0] b);
    esperado_t e;
    e.pulsos  = p;
    e.balance = b;
    e.ciclo   = cycleCount + 1;
    colaEsperada.push_back(e);
  endfunction

  always @(negedge clk) begin : monitor
    logic [7:0] vis;
    esperado_t  e;
    if (rstN) begin
      vis = {balAct, entregar, fondos, pinInc, adv, desborde, limite, balValid};
      checkOutput("bloqueo", 64'(bloqueo), 64'(expBloqueo));
      while (colaEsperada.size() > 0 && colaEsperada[0].ciclo < cycleCount) begin
        e = colaEsperada.pop_front();
        checkOutput("pulso_ausente", 64'(0), 64'(e.pulsos));
      end
      if (colaEsperada.size() > 0 && colaEsperada[0].ciclo == cycleCount) begin
        e = colaEsperada.pop_front();
        checkOutput("pulsos", 64'(vis), 64'(e.pulsos));
        if (e.pulsos[P_VAL]) checkOutput("balance_out", 64'(balOut), 64'(e.balance));
      end else if (vis != 8'h00) begin
        checkOutput("pulso_inesperado", 64'(vis), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseDigit(logic [3:0] d);
    digito = d; digitoStb = 1'b1;
    tick();
    digitoStb = 1'b0;
  endtask

  task automatic doTipo(logic [1:0] t);
    tipo = t; tipoStb = 1'b1;
    tick();
    tipoStb = 1'b0;
  endtask

  task automatic doMonto(logic [MW-1:0] m);
    monto = m; montoStb = 1'b1;
    tick();
    montoStb = 1'b0;
  endtask

  function automatic logic [15:0] randomPin();
    logic [15:0] p;
    for (int i = 0; i < 4; i++) p[4*i +: 4] = 4'($urandom_range(0, 9));
    return p;
  endfunction

  task automatic insertCard(int a);
    tarjeta = 1'b1;
    cuentaId = 2'(a);
    tick();
    if (lockM[a]) expBloqueo = 1'b1;
    else acumM = 0;
  endtask

  task automatic removeCard();
    tarjeta = 1'b0;
    tick();
    expBloqueo = 1'b0;
    acumM = 0;
  endtask

  // Strobes that must all be dropped in the current state.
  task automatic applyStimulus(int ciclos);
    for (int k = 0; k < ciclos; k++) begin
      digito = 4'($urandom_range(0, 9));
      tipo = 2'($urandom_range(0, 3));
      monto = $urandom_range(0, 500);
      digitoStb = 1'($urandom_range(0, 1));
      tipoStb = 1'($urandom_range(0, 1));
      montoStb = 1'($urandom_range(0, 1));
      tick();
      digitoStb = 1'b0; tipoStb = 1'b0; montoStb = 1'b0;
    end
  endtask

  task automatic enterPin(int a, logic [15:0] p, output bit ok, output bit locked);
    logic [7:0] pulsos;
    for (int i = 0; i < 4; i++) begin
      pulseDigit(p[15-4*i -: 4]);
      if (i < 3 && $urandom_range(0, 3) == 0) tick();
    end
    ok = (p == pinDe[a]);
    locked = 1'b0;
    if (ok) begin
      intentosM[a] = 0;
    end else begin
      intentosM[a]++;
      pulsos = '0;
      pulsos[P_PIN] = 1'b1;
      if (intentosM[a] == MI - 1) pulsos[P_ADV] = 1'b1;
      if (intentosM[a] == MI) begin
        lockM[a] = 1'b1;
        intentosM[a] = 0;
        locked = 1'b1;
      end
      pushEsperado(pulsos, '0);
    end
    if ($urandom_range(0, 1) == 1) pulseDigit(4'($urandom_range(0, 9)));
    else tick();
    if (locked) expBloqueo = 1'b1;
  endtask

  task automatic openSession(int a, output bit ok);
    bit locked;
    insertCard(a);
    enterPin(a, pinDe[a], ok, locked);
  endtask

  task automatic opDeposit(int a, logic [MW-1:0] m);
    logic [7:0] pulsos = '0;
    doTipo(2'b00);
    if (saldoM[a] + longint'(m) > 64'hFFFF_FFFF) begin
      pulsos[P_DES] = 1'b1;
    end else begin
      saldoM[a] += m;
      pulsos[P_ACT] = 1'b1;
    end
    pushEsperado(pulsos, '0);
    doMonto(m);
  endtask

  task automatic opWithdraw(int a, logic [MW-1:0] m);
    logic [7:0] pulsos = '0;
    bit limitado = 1'b0;
    doTipo(2'b01);
`ifdef CAJERO_LIMITE_RETIRO_EN
    limitado = (acumM + longint'(m) > LIM);
`endif
    if (longint'(m) > saldoM[a]) begin
      pulsos[P_FON] = 1'b1;
    end else if (limitado) begin
      pulsos[P_LIM] = 1'b1;
    end else begin
      saldoM[a] -= m;
      acumM += m;
      pulsos[P_ACT] = 1'b1;
      pulsos[P_ENT] = 1'b1;
    end
    pushEsperado(pulsos, '0);
    doMonto(m);
  endtask

  task automatic opInquiry(int a);
    logic [7:0] pulsos = '0;
    pulsos[P_VAL] = 1'b1;
    pushEsperado(pulsos, MW'(saldoM[a]));
    doTipo(2'b10);
  endtask

  task automatic removeDuringWithdraw(logic [MW-1:0] m);
    doTipo(2'b01);
    tarjeta = 1'b0;
    monto = m; montoStb = 1'b1;
    tick();
    montoStb = 1'b0;
    expBloqueo = 1'b0;
    acumM = 0;
  endtask

  task automatic randomSession();
    int a = $urandom_range(0, N-1);
    bit ok = 1'b0;
    bit locked;
    int nOps;
    logic [MW-1:0] m;
    insertCard(a);
    if (lockM[a]) begin
      applyStimulus(3);
      removeCard();
      return;
    end
    while (!ok) begin
      enterPin(a, ($urandom_range(0, 99) < 60) ? pinDe[a] : randomPin(), ok, locked);
      if (locked) begin
        applyStimulus(3);
        removeCard();
        return;
      end
      if (!ok && $urandom_range(0, 3) == 0) begin
        removeCard();
        return;
      end
    end
    nOps = $urandom_range(1, 6);
    for (int k = 0; k < nOps; k++) begin
      case ($urandom_range(0, 7))
        0, 1: begin
          m = ($urandom_range(0, 7) == 0) ? MW'(64'hFFFF_FFFF - $urandom_range(0, 3000))
                                          : MW'($urandom_range(0, 3000));
          opDeposit(a, m);
        end
        2, 3: begin
          case ($urandom_range(0, 4))
            0: m = MW'(saldoM[a]);
            1: m = MW'(saldoM[a] + 1 + $urandom_range(0, 100));
            2: m = '0;
            default: m = MW'($urandom_range(0, 1500));
          endcase
          opWithdraw(a, m);
        end
        4: opInquiry(a);
        5: doMonto(MW'($urandom_range(1, 100)));
        6: begin
          doTipo(2'b11);
          applyStimulus(2);
          removeCard();
          return;
        end
        default: begin
          removeDuringWithdraw(MW'($urandom_range(0, 100)));
          return;
        end
      endcase
    end
    removeCard();
  endtask

  function automatic void resetModel();
    for (int i = 0; i < N; i++) begin
      saldoM[i] = 0;
      intentosM[i] = 0;
      lockM[i] = 1'b0;
    end
    acumM = 0;
    expBloqueo = 1'b0;
  endfunction

  initial begin
    bit ok, locked;
    pinDe[0] = 16'h9876;
    pinDe[1] = randomPin();
    pinDe[2] = 16'h1234;
    pinDe[3] = randomPin();
    resetModel();

    tick(); tick();
    checkOutput("reset_salidas",
      64'({balAct, entregar, fondos, pinInc, adv, desborde, limite, balValid, bloqueo, balOut}), 64'(0));
    rstN = 1'b1;
    tick();

    $display("[TB] deposit and inquiry on account 2");
    openSession(2, ok);
    opDeposit(2, 500);
    opInquiry(2);
    removeCard();

    $display("[TB] three wrong PINs lock account 0");
    insertCard(0);
    for (int k = 0; k < 3; k++) enterPin(0, 16'h0000, ok, locked);
    applyStimulus(2);
    removeCard();
    insertCard(0);
    applyStimulus(2);
    removeCard();
    openSession(1, ok);
    opInquiry(1);
    removeCard();

    $display("[TB] insufficient funds and exact withdrawal on account 1");
    openSession(1, ok);
    opDeposit(1, 100);
    opWithdraw(1, 150);
    opInquiry(1);
    opWithdraw(1, 100);
    opInquiry(1);
    removeCard();

    $display("[TB] deposit overflow on account 3");
    openSession(3, ok);
    opDeposit(3, 200);
    opDeposit(3, 32'hFFFF_FFFF - 100);
    opInquiry(3);
    opWithdraw(3, 0);
    removeDuringWithdraw(50);
    openSession(3, ok);
    opInquiry(3);
    removeCard();

    $display("[TB] session withdrawal cap on account 1");
    openSession(1, ok);
    opDeposit(1, 5000);
    opWithdraw(1, 600);
    opWithdraw(1, 500);
    opInquiry(1);
    removeCard();
    openSession(1, ok);
    opWithdraw(1, 500);
    opInquiry(1);
    removeCard();

    $display("[TB] asynchronous reset in the middle of PIN entry");
    insertCard(3);
    pulseDigit(4'd1);
    pulseDigit(4'd2);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("reset_async_salidas",
      64'({balAct, entregar, fondos, pinInc, adv, desborde, limite, balValid, bloqueo, balOut}), 64'(0));
    resetModel();
    colaEsperada.delete();
    tarjeta = 1'b0;
    tick(); tick();
    rstN = 1'b1;
    tick();
    openSession(3, ok);
    opInquiry(3);
    removeCard();
    openSession(0, ok);
    opInquiry(0);
    removeCard();

    $display("[TB] random sessions");
    for (int s = 0; s < 250; s++) randomSession();

    tick(); tick(); tick();
    checkOutput("cola_pendiente", 64'(colaEsperada.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cajero_multicuenta.md
# cajero_multicuenta

Parametrised successor of the single-account ATM controller: serves N_CUENTAS accounts with independent balances, attempt counters and lock flags. Adds configurable PIN length, amount width, attempt limit, multiple transactions per session, balance inquiry, session cancel and deposit-overflow rejection. Sits between the card/keypad front-end and the cash dispenser; all results are registered single-cycle pulses.

## Interface
- N_CUENTAS, 4: number of accounts (≥2).
- PIN_DIGITOS, 4: BCD digits per PIN.
- MONTO_W, 32: balance/amount width, unsigned.
- MAX_INTENTOS, 3: wrong PINs before lock (≥2).
- LIMITE_RETIRO, 1000: per-session withdrawal cap (used only with macro).
- Clk  in  1  clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low.
- TARJETA_RECIBIDA  in  1  card present (level).
- CUENTA_ID  in  clog2(N_CUENTAS)  account of inserted card; sampled on leaving IDLE.
- PIN  in  4*PIN_DIGITOS  correct PIN of that account, first digit in MSBs.
- DIGITO  in  4  keypad digit; DIGITO_STB  in  1  digit valid.
- TIPO_TRANS  in  2  00 deposit, 01 withdraw, 10 inquiry, 11 cancel; TIPO_STB  in  1  valid.
- MONTO  in  MONTO_W  amount; MONTO_STB  in  1  valid.
- BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES, PIN_INCORRECTO, ADVERTENCIA, DESBORDE, LIMITE_EXCEDIDO, BALANCE_VALID  out  1  one-cycle pulses.
- Bloqueo  out  1  level, high while in BLOQUEADO.
- BALANCE_OUT  out  MONTO_W  session account balance, meaningful when BALANCE_VALID.

## Operation
- States: IDLE, PIN, SELECCION, DEPOSITO, RETIRO, BLOQUEADO, FIN.
- Reset: state IDLE, all balances 0, attempt counters 0, lock flags 0, digit count 0, PIN shift reg 0, all outputs 0.
- Card removal (TARJETA_RECIBIDA=0) in any non-IDLE state → IDLE next edge; clears digit count/shift reg, session total; beats every simultaneous strobe; no pulses.
- IDLE: TARJETA_RECIBIDA=1 → latch CUENTA_ID; if account locked → BLOQUEADO, else PIN.
- PIN: each DIGITO_STB shifts DIGITO in from the LSB, count+1. Cycle after count reaches PIN_DIGITOS: compare (further DIGITO_STB ignored that cycle), count/shift reg cleared.
  - Match: counter[acct]←0, → SELECCION.
  - Mismatch: counter+1, PIN_INCORRECTO; new value MAX_INTENTOS-1 adds ADVERTENCIA; new value MAX_INTENTOS sets lock[acct], counter←0, → BLOQUEADO; else stay PIN.
- Counters and locks persist across sessions; only Reset clears locks.
- SELECCION: on TIPO_STB: 00→DEPOSITO, 01→RETIRO, 10→BALANCE_OUT=balance, BALANCE_VALID, stay; 11→FIN. MONTO_STB ignored.
- DEPOSITO: on MONTO_STB, MONTO_W+1-bit sum; carry → DESBORDE, balance unchanged; else balance+=MONTO, BALANCE_ACTUALIZADO. → SELECCION either way.
- RETIRO: on MONTO_STB: MONTO>balance → FONDOS_INSUFICIENTES; limit check (macro); else balance-=MONTO, BALANCE_ACTUALIZADO+ENTREGAR_DINERO. → SELECCION. MONTO=0 succeeds.
- BLOQUEADO, FIN: ignore all strobes; leave only on card removal.

## Timing
- All outputs registered; a pulse is high for the one cycle after the edge sampling its trigger.
- Last digit at edge N → compare at edge N+1 → PIN_INCORRECTO/ADVERTENCIA in cycle N+1..N+2; state SELECCION/BLOQUEADO after edge N+1.
- TIPO_STB/MONTO_STB at edge N → result pulse and state change after edge N. Strobes in the wrong state are dropped, not queued.
- Bloqueo rises on the edge entering BLOQUEADO, falls on the edge leaving.
- Reset asserted mid-transaction: outputs, state and storage clear immediately, no pulse completes.

## Configuration
- CAJERO_LIMITE_RETIRO_EN defined: per-session accumulator (MONTO_W+1 bits) of successful withdrawals; withdrawal with accumulator+MONTO > LIMITE_RETIRO → LIMITE_EXCEDIDO, balance unchanged; funds check first, FONDOS_INSUFICIENTES takes priority. Accumulator cleared on entering PIN and on card removal.
- Undefined: no accumulator, LIMITE_EXCEDIDO tied 0, only funds check.

## Test plan
- Acct 2, PIN 1234; digits 1,2,3,4; TIPO 00, MONTO 500 → BALANCE_ACTUALIZADO; TIPO 10 → BALANCE_OUT=500, BALANCE_VALID.
- Acct 0 wrong PIN 0000 ×3 → PIN_INCORRECTO each; ADVERTENCIA with 2nd; 3rd gives BLOQUEADO, Bloqueo=1; remove/reinsert → straight to BLOQUEADO; acct 1 still usable.
- Balance 100, withdraw 150 → FONDOS_INSUFICIENTES, balance 100; withdraw 100 → ENTREGAR_DINERO, balance 0.
- MONTO_W=8, balance 200, deposit 100 → DESBORDE, balance 200.
- Macro on, LIMITE_RETIRO=1000, balance 5000: withdraw 600 ok, withdraw 500 → LIMITE_EXCEDIDO; remove card, new session, withdraw 500 ok.
- Card removed same cycle as MONTO_STB in RETIRO → IDLE, no pulses, balance unchanged; Reset low mid-PIN → all outputs 0, balances 0.
